crab_mem_responder: RTL and testbench

//   Memory-side responder for crabcore's request/ready memory port. Accepts

---
 rtl/crab_mem_responder.sv | 154 +++++++++++++++
 tb/tb_crab_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/crab_mem_responder.sv
// crab_mem_responder
//   Memory-side responder for the crabcore request/ready memory port. A core
//   request is captured in IDLE, waits LATENCY cycles, then completes with a
//   one-cycle mem_ready pulse. Reads return RAM data on mem_input (held until
//   the next read response); writes commit to RAM at the end of the response
//   cycle. A backdoor port preloads program images at any time.
//
//   Optional feature: define CRAB_MEM_ERR_EN to add the mem_error output,
//   flagging out-of-range or misaligned accesses during the response cycle.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   mem_addr_valid, mem_addr    core request valid, byte address
//   mem_data_valid, mem_data    write qualifier and write data
//   mem_ready                   one-cycle completion pulse
//   mem_input                   read data
//   load_we/load_addr/load_data backdoor word write
//   mem_error                   (CRAB_MEM_ERR_EN only) access error flag
//
// state | meaning
// IDLE  | waiting for mem_addr_valid
// WAIT  | latency countdown on captured request
// RESP  | mem_ready high; write commits at the end of this cycle
module crab_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_addr_valid,
  input  logic [31:0]           mem_addr,
  input  logic                  mem_data_valid,
  input  logic [31:0]           mem_data,
  output logic                  mem_ready,
  output logic [31:0]           mem_input,
  input  logic                  load_we,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
`ifdef CRAB_MEM_ERR_EN
  ,
  output logic                  mem_error
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [7:0] LAT_M1 = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state_q, state_d;
  logic [7:0]            cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  oor_q;
  logic                  mis_q;
  logic                  wr_q;
  logic [31:0]           data_q;

  logic [31:0] ram [DEPTH];

  // Decode of the live request, used on the accept edge.
  logic [DEPTH_LOG2-1:0] in_idx;
  logic                  in_oor;
  logic                  in_mis;
  logic                  accept;

  assign in_idx = mem_addr[DEPTH_LOG2+1:2];
  assign in_oor = |mem_addr[31:DEPTH_LOG2+2];
  assign in_mis = |mem_addr[1:0];
  assign accept = (state_q == S_IDLE) && mem_addr_valid;

  // With LATENCY=0 RESP is entered straight from IDLE, before the captured
  // copy exists, so the read on that edge must use the live request.
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                  cur_oor;
  logic                  cur_wr;
  logic                  enter_resp;

  assign cur_idx    = (state_q == S_IDLE) ? in_idx : idx_q;
  assign cur_oor    = (state_q == S_IDLE) ? in_oor : oor_q;
  assign cur_wr     = (state_q == S_IDLE) ? mem_data_valid : wr_q;
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      idx_q     <= '0;
      oor_q     <= 1'b0;
      mis_q     <= 1'b0;
      wr_q      <= 1'b0;
      data_q    <= 32'd0;
      mem_input <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q  <= LAT_M1;
        idx_q  <= in_idx;
        oor_q  <= in_oor;
        mis_q  <= in_mis;
        wr_q   <= mem_data_valid;
        data_q <= mem_data;
      end else if (state_q == S_WAIT && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (enter_resp && !cur_wr) begin
        mem_input <= cur_oor ? 32'd0 : ram[cur_idx];
      end
    end
  end

  // RAM: the core commit is written last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (load_we) begin
      ram[load_addr] <= load_data;
    end
    if (state_q == S_RESP && wr_q && !oor_q && !reset) begin
      ram[idx_q] <= data_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_addr_valid) begin
          state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_ready = (state_q == S_RESP);
`ifdef CRAB_MEM_ERR_EN
    mem_error = (state_q == S_RESP) && (oor_q || mis_q);
`endif
  end

`ifndef CRAB_MEM_ERR_EN
  logic unused_err_bits;
  assign unused_err_bits = mis_q;
`endif

endmodule

// File: tb/tb_crab_mem_responder.sv
module tb_crab_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        av   [2];
  logic        dv   [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic        rdy  [2];
  logic [31:0] rdat [2];
  logic        err  [2];
  logic        load_we = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crab_mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset),
    .mem_addr_valid(av[0]), .mem_addr(addr[0]),
    .mem_data_valid(dv[0]), .mem_data(wdat[0]),
    .mem_ready(rdy[0]), .mem_input(rdat[0]),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
`ifdef CRAB_MEM_ERR_EN
    , .mem_error(err[0])
`endif
  );

  crab_mem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(reset),
    .mem_addr_valid(av[1]), .mem_addr(addr[1]),
    .mem_data_valid(dv[1]), .mem_data(wdat[1]),
    .mem_ready(rdy[1]), .mem_input(rdat[1]),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
`ifdef CRAB_MEM_ERR_EN
    , .mem_error(err[1])
`endif
  );

`ifndef CRAB_MEM_ERR_EN
  initial begin
    err[0] = 1'b0;
    err[1] = 1'b0;
  end
`endif

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  task automatic check_resp(input int u);
    exp_t e;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_ready u%0d: got ready with no request pending (cycle %0d)", u, cyc);
    end else begin
      if (u == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("ready_cycle u%0d", u), 32'(cyc), 32'(e.cyc));
      chk($sformatf("mem_input u%0d", u), rdat[u], e.data);
`ifdef CRAB_MEM_ERR_EN
      chk($sformatf("mem_error u%0d", u), {31'd0, err[u]}, {31'd0, e.err});
`endif
    end
  endtask

  // Monitors: sample at the falling edge, away from the active edge.
  always @(negedge clk) if (rdy[0] === 1'b1) check_resp(0);
  always @(negedge clk) if (rdy[1] === 1'b1) check_resp(1);

  task automatic do_req(input int u, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [31:0] exp_d, input logic exp_e,
                        input bit scramble, input bit collide);
    exp_t e;
    bit   seen;
    e.cyc  = cyc + 1 + ((u == 0) ? 2 : 0);
    e.data = exp_d;
    e.err  = exp_e;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
    av[u] = 1'b1; addr[u] = a; wdat[u] = d; dv[u] = w;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (scramble && i == 0) begin
        addr[u] = 32'hFFFF_FFF0; wdat[u] = 32'h5A5A_5A5A; dv[u] = ~w;
      end
      if (rdy[u]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout u%0d: got no ready expected ready for addr %h", u, a);
    end
    if (collide) begin
      load_we = 1'b1; load_addr = a[11:2]; load_data = 32'h0BAD_0BAD;
    end
    @(posedge clk); #1;
    av[u] = 1'b0; dv[u] = 1'b0; load_we = 1'b0;
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      av[u] = 1'b0; dv[u] = 1'b0; addr[u] = '0; wdat[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_ready", {31'd0, rdy[0]}, 32'd0);
    chk("reset_input", rdat[0], 32'd0);

    bd_write(10'd4, 32'hDEAD_BEEF);
    bd_write(10'd0, 32'h1111_1111);
    bd_write(10'd1, 32'h2222_2222);
    bd_write(10'd2, 32'hAAAA_0002);

    // Preloaded words must survive a second reset.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset2_ready", {31'd0, rdy[0]}, 32'd0);
    chk("reset2_input", rdat[0], 32'd0);

    do_req(0, 32'h10,   32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    do_req(0, 32'h20,   32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    do_req(0, 32'h20,   32'h0,         1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    do_req(0, 32'h1000, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b0);
    do_req(0, 32'h1000, 32'h0000_0055, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0);
    do_req(0, 32'h0,    32'h0,         1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    do_req(0, 32'h2,    32'h0,         1'b0, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
    do_req(0, 32'h7,    32'h0,         1'b0, 32'h2222_2222, 1'b1, 1'b0, 1'b0);

    // Write data without an address strobe is not a request.
    dv[0] = 1'b1; wdat[0] = 32'hFFFF_0000;
    repeat (4) @(posedge clk);
    #1 dv[0] = 1'b0;

    // Reset while the write to 0x8 is in WAIT aborts it.
    av[0] = 1'b1; dv[0] = 1'b1; addr[0] = 32'h8; wdat[0] = 32'h9999_9999;
    @(posedge clk); #1;
    reset = 1'b1; av[0] = 1'b0; dv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_ready", {31'd0, rdy[0]}, 32'd0);
    chk("abort_input", rdat[0], 32'd0);
    repeat (4) @(posedge clk);
    #1;
    do_req(0, 32'h8,    32'h0,         1'b0, 32'hAAAA_0002, 1'b0, 1'b0, 1'b0);

    do_req(0, 32'hC,    32'hC0C0_C0C0, 1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 1'b1);
    do_req(0, 32'hC,    32'h0,         1'b0, 32'hC0C0_C0C0, 1'b0, 1'b0, 1'b0);

    // Zero-latency instance: back-to-back reads, ready at T+1 and T+3.
    do_req(1, 32'h0,    32'h0,         1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    do_req(1, 32'h4,    32'h0,         1'b0, 32'h2222_2222, 1'b0, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("pending_u0", 32'(q0.size()), 32'd0);
    chk("pending_u1", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
